mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage; sits between EX and WB. Registers the EX->MEM bus and
//  sign/zero-extends synchronous data-SRAM read data for LB/LBU/LH/LHU/LW.
//  Forwards the final register result and HI/LO writes to WB and back to ID for bypass.
//  Holds SRAM read data across MEM stalls, because the SRAM output is not stable while the stage is frozen.
// PARAMETERS
//  EX_TO_MEM_WD  146  EX->MEM bus width {readen[4],hi_we,lo_we,hi[32],lo[32],pc[32],ram_en,ram_wen[4],sel_rf_res,rf_we,rf_waddr[5],ex_result[32]}
//  MEM_TO_WB_WD  136  MEM->WB bus width {hi_we,lo_we,hi[32],lo[32],pc[32],rf_we,rf_waddr[5],rf_wdata[32]}
//  MEM_TO_ID_WD  104  bypass bus width {rf_we,rf_waddr[5],rf_wdata[32],hi_we,lo_we,hi[32],lo[32]}
// PORTS
//  clk              in   1             clock, all state on posedge
//  resetn           in   1             synchronous, active-low reset
//  stall            in   `StallBus     pipeline stall vector; stall[3]=MEM, stall[4]=WB
//  ex_to_mem_bus    in   EX_TO_MEM_WD  EX stage output
//  data_sram_rdata  in   32            SRAM read word; valid the cycle after EX drove its address
//  mem_to_wb_bus    out  MEM_TO_WB_WD  to WB pipeline register
//  mem_to_id_bus    out  MEM_TO_ID_WD  bypass to ID
//  mem_is_load      out  1             registered instruction is a load (readen in LB..LW set)
// BEHAVIOUR
//  - Clock and reset: one clock, clk. resetn is synchronous and active-low.
//  - Pipeline register bus_r, with the following priority:
//    - resetn=0 -> 0.
//    - stall[3]=Stop and stall[4]=NoStop -> 0 (bubble).
//    - stall[3]=NoStop -> ex_to_mem_bus.
//    - otherwise hold.
//  - Outputs at reset: bus_r=0, so every output is 0 (rf_we=0, hi_we=lo_we=0, mem_is_load=0).
//  - Readen codes (shared defines):
//    - 0000 none; 0001 LB; 0010 LBU; 0011 LH; 0100 LHU; 1111 LW.
//    - 0101 SB; 0111 SH. Stores: no read data is used.
//  - Read-data hold:
//    - Registers: hold_vld, hold_data.
//    - If hold_vld=0 and stall[4]=Stop, then the next cycle hold_vld=1 and hold_data=data_sram_rdata.
//    - When stall[4]=NoStop (stage advances), the next cycle hold_vld=0.
//    - Effective word: rword = hold_vld ? hold_data : data_sram_rdata.
//    - resetn=0 clears hold_vld and hold_data. A reset in mid-stall drops the held word.
//  - Byte/half select uses addr=ex_result[1:0]:
//    - LB/LBU: byte at addr*8, sign/zero-extended to 32.
//    - LH/LHU: half at addr[1]*16; addr[0] is ignored (misalignment is trapped upstream).
//    - LW: rword.
//  - rf_wdata = sel_rf_res ? loaded value : ex_result.
//  - hi_we, lo_we, hi, lo and pc pass through unchanged. rf_we and rf_waddr pass through.
//  - mem_to_id_bus carries the same rf/HI/LO values as mem_to_wb_bus in the same cycle. It is fully combinational from bus_r and rword.
//  - Latency: 1 cycle of register from EX; the outputs are combinational from there. No handshake beyond stall.
//  - Bubble case: bus_r=0, so rf_we=0 and hi_we=lo_we=0. The ID bypass must see no write.
//  - Simultaneous events:
//    - Load and bubble in the same edge: the bubble wins. hold_vld clears because stall[4]=NoStop.
//    - stall[3]=Stop and stall[4]=Stop: both bus_r and hold are kept.
// STRUCTURE
//  - lib/defines.vh holds:
//    - bus widths (EX_TO_MEM_WD, MEM_TO_WB_WD, MEM_TO_ID_WD);
//    - readen codes (`LD_LB .. `LD_LW, `ST_SB, `ST_SH);
//    - Stop/NoStop and StallBus.
//  - Sub-module: load_align (combinational) with inputs {readen, addr[1:0], rword} and output the extended 32-bit value.
//  - mem_stage owns bus_r, the hold logic and bus packing.
// TESTING
//  1. Reset: resetn=0 for 2 cycles -> both out buses all-zero and mem_is_load=0. Release -> still zero until EX drives.
//  2. LB at addr[1:0]=11 with rdata=0x80FF_1234 -> rf_wdata=0xFFFF_FF80. LBU with the same stimulus -> 0x0000_0080.
//  3. LH at addr=10 with rdata=0x8001_7FFF -> 0xFFFF_8001. LHU at addr=00 -> 0x0000_7FFF. LW -> 0x8001_7FFF.
//  4. Load with stall[4]=Stop for 3 cycles while rdata changes to 0xDEAD_BEEF after the first cycle -> output stays at the first-cycle value, then advances with hold_vld=0.
//  5. stall[3]=Stop, stall[4]=NoStop -> next cycle rf_we=0 and hi_we=lo_we=0 on both buses.
//  6. MULT passthrough (hi_we=lo_we=1, hi=0x1, lo=0x2, sel_rf_res=0) -> identical values on both buses in the same cycle. Assert resetn=0 mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the bus widths, the load/store readen codes, the stall encoding and
// packed-struct views of the EX->MEM, MEM->WB and MEM->ID buses. The struct
// field order matches the flat bus layout, most-significant field first.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 146;
  localparam int MEM_TO_WB_WD = 136;
  localparam int MEM_TO_ID_WD = 104;
  localparam int STALL_WD     = 6;

  // Stall vector: one bit per stage; stall[3]=MEM, stall[4]=WB.
  localparam int  STALL_MEM = 3;
  localparam int  STALL_WB  = 4;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // readen codes.
  localparam logic [3:0] LD_NONE = 4'b0000;
  localparam logic [3:0] LD_LB   = 4'b0001;
  localparam logic [3:0] LD_LBU  = 4'b0010;
  localparam logic [3:0] LD_LH   = 4'b0011;
  localparam logic [3:0] LD_LHU  = 4'b0100;
  localparam logic [3:0] LD_LW   = 4'b1111;
  localparam logic [3:0] ST_SB   = 4'b0101;
  localparam logic [3:0] ST_SH   = 4'b0111;

  typedef struct packed {
    logic [3:0]  readen;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_wb_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } mem_to_id_t;

  // True for the five codes that consume SRAM read data.
  function automatic logic is_load(input logic [3:0] readen);
    return (readen == LD_LB) || (readen == LD_LBU) || (readen == LD_LH) ||
           (readen == LD_LHU) || (readen == LD_LW);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational byte/half/word select and extension of the SRAM
// read word.
// Ports:
//   readen - load code (LB/LBU/LH/LHU/LW; anything else yields 0)
//   addr   - low two bits of the effective address
//   rword  - 32-bit read word (live SRAM data or the held copy)
//   value  - extended 32-bit load result
module load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  readen,
  input  logic [1:0]  addr,
  input  logic [31:0] rword,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword[7:0];
    case (addr)
      2'b00: byte_sel = rword[7:0];
      2'b01: byte_sel = rword[15:8];
      2'b10: byte_sel = rword[23:16];
      2'b11: byte_sel = rword[31:24];
      default: byte_sel = rword[7:0];
    endcase
  end

  // addr[0] is ignored for halfwords: misaligned accesses never reach here.
  assign half_sel = addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    value = '0;
    case (readen)
      LD_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  value = {24'h0, byte_sel};
      LD_LH:   value = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  value = {16'h0, half_sel};
      LD_LW:   value = rword;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Registers the EX->MEM bus, extends SRAM read data for loads, and presents
// the register/HI/LO results to WB and to the ID bypass network.
// Ports:
//   clk             - clock, all state on posedge
//   resetn          - synchronous active-low reset
//   stall           - stall vector; stall[3]=MEM, stall[4]=WB
//   ex_to_mem_bus   - EX stage output bus
//   data_sram_rdata - SRAM read word, valid the cycle after EX drove the address
//   mem_to_wb_bus   - to WB pipeline register
//   mem_to_id_bus   - bypass to ID (same rf/HI/LO values as mem_to_wb_bus)
//   mem_is_load     - registered instruction is a load
// Flow control is the stall vector only: the stage takes a new EX bus when
// stall[3] is NoStop, inserts a bubble when MEM stops but WB runs, and
// otherwise holds. There is no valid/ready handshake.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic                    mem_is_load
);

  ex_to_mem_t  bus_r;
  logic        hold_vld;
  logic [31:0] hold_data;
  logic [31:0] rword;
  logic [31:0] load_value;
  logic [31:0] rf_wdata;
  mem_to_wb_t  wb_s;
  mem_to_id_t  id_s;

  // Pipeline register: reset > bubble > advance > hold.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus_r <= '0;
    end else if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP) begin
      bus_r <= '0;
    end else if (stall[STALL_MEM] == NO_STOP) begin
      bus_r <= ex_to_mem_bus;
    end
  end

  // The SRAM output is only valid for one cycle, so the first word seen
  // while WB is stopped is captured and used until the stage advances.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (!hold_vld && stall[STALL_WB] == STOP) begin
      hold_vld  <= 1'b1;
      hold_data <= data_sram_rdata;
    end else if (stall[STALL_WB] == NO_STOP) begin
      hold_vld  <= 1'b0;
    end
  end

  assign rword = hold_vld ? hold_data : data_sram_rdata;

  load_align u_load_align (
    .readen (bus_r.readen),
    .addr   (bus_r.ex_result[1:0]),
    .rword  (rword),
    .value  (load_value)
  );

  assign rf_wdata = bus_r.sel_rf_res ? load_value : bus_r.ex_result;

  always_comb begin
    wb_s          = '0;
    wb_s.hi_we    = bus_r.hi_we;
    wb_s.lo_we    = bus_r.lo_we;
    wb_s.hi       = bus_r.hi;
    wb_s.lo       = bus_r.lo;
    wb_s.pc       = bus_r.pc;
    wb_s.rf_we    = bus_r.rf_we;
    wb_s.rf_waddr = bus_r.rf_waddr;
    wb_s.rf_wdata = rf_wdata;
  end

  always_comb begin
    id_s          = '0;
    id_s.rf_we    = bus_r.rf_we;
    id_s.rf_waddr = bus_r.rf_waddr;
    id_s.rf_wdata = rf_wdata;
    id_s.hi_we    = bus_r.hi_we;
    id_s.lo_we    = bus_r.lo_we;
    id_s.hi       = bus_r.hi;
    id_s.lo       = bus_r.lo;
  end

  assign mem_to_wb_bus = wb_s;
  assign mem_to_id_bus = id_s;
  assign mem_is_load   = is_load(bus_r.readen);

  // SRAM enables were consumed by EX; other stall bits belong to other stages.
  logic unused_bits;
  assign unused_bits = ^{bus_r.ram_en, bus_r.ram_wen,
                         stall[STALL_WD-1], stall[STALL_MEM-1:0]};

endmodule
